// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator processor control path:
// opcode and FSM state encodings, datapath select codes and decode helpers.
package cpu_pkg;

  // 5-bit opcode map. Unlisted encodings decode as NOP.
  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BGT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_BLT  = 5'b01100,
    OP_BLE  = 5'b01101,
    OP_JMP  = 5'b01110
  } opcode_t;

  // Control FSM states. PAUSE is reachable only in the single-step build.
  typedef enum logic [2:0] {
    FETCH = 3'd0,
    LATCH = 3'd1,
    MEM   = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4,
    PAUSE = 3'd5
  } cu_state_t;

  // Accumulator source select codes.
  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_EXT = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  // ALU operation codes.
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Instructions that need a data-memory read cycle before execution.
  function automatic logic needs_mem_read(input opcode_t op);
    return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Branch resolution from the datapath status flags.
  function automatic logic branch_taken(input opcode_t op, input logic z, input logic n);
    logic taken;
    case (op)
      OP_BEQ:  taken = z;
      OP_BNE:  taken = !z;
      OP_BGT:  taken = !z && !n;
      OP_BGE:  taken = !n;
      OP_BLT:  taken = n;
      OP_BLE:  taken = n || z;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage : cpu_pkg

// File: rtl/program_counter.sv
// Program counter: synchronous active-high reset, parallel load for taken
// branches/jumps, and increment that wraps modulo 2^OPERAND_WIDTH.
module program_counter #(
  parameter int OPERAND_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     inc,
  input  logic [OPERAND_WIDTH-1:0] load_value,
  output logic [OPERAND_WIDTH-1:0] pc
);

  // PC register; load wins over increment, reset wins over both.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + OPERAND_WIDTH'(1);
    end
  end

endmodule : program_counter

// File: rtl/control_unit.sv
// Multi-cycle control unit for the 16-bit accumulator processor.
// Fetches into IR through a synchronous program memory, decodes the opcode
// and drives datapath selects/strobes for exactly one EXEC cycle.
// Optional build macro CONTROL_UNIT_STEP_EN adds a step_in port and a PAUSE
// state entered after every EXEC, released by a step_in pulse.
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int OPCODE_WIDTH  = 5
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
`ifdef CONTROL_UNIT_STEP_EN
  input  logic                     step_in,
`endif
  input  logic [DATA_WIDTH-1:0]    instruction_in,
  input  logic                     status_Z_in,
  input  logic                     status_N_in,
  output logic [OPERAND_WIDTH-1:0] program_address_out,
  output logic [OPERAND_WIDTH-1:0] operand_out,
  output logic [1:0]               sel_A_out,
  output logic                     sel_B_out,
  output logic                     alu_op_out,
  output logic                     acc_wr_out,
  output logic                     status_wr_out,
  output logic                     acc_reset_out,
  output logic                     status_reset_out,
  output logic                     data_memory_wr_out,
  output logic                     halted_out
);

  if (DATA_WIDTH != OPCODE_WIDTH + OPERAND_WIDTH) begin : g_width_check
    $error("control_unit: DATA_WIDTH must equal OPCODE_WIDTH + OPERAND_WIDTH");
  end

  cu_state_t                state;
  cu_state_t                next_state;
  logic [DATA_WIDTH-1:0]    ir;
  logic [OPERAND_WIDTH-1:0] pc;
  logic                     pc_load;
  logic                     pc_inc;
  opcode_t                  fetched_op;
  opcode_t                  exec_op;

  assign fetched_op = opcode_t'(instruction_in[DATA_WIDTH-1 -: OPCODE_WIDTH]);
  assign exec_op    = opcode_t'(ir[DATA_WIDTH-1 -: OPCODE_WIDTH]);

  program_counter #(
    .OPERAND_WIDTH(OPERAND_WIDTH)
  ) u_program_counter (
    .clk        (clock_in),
    .reset      (reset_in),
    .load       (pc_load),
    .inc        (pc_inc),
    .load_value (ir[OPERAND_WIDTH-1:0]),
    .pc         (pc)
  );

  // State register and instruction register; IR captures memory data in LATCH.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= FETCH;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == LATCH) begin
        ir <= instruction_in;
      end
    end
  end

  // Next-state logic, EXEC-cycle decode and PC control; all zero during reset.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    next_state         = state;
    sel_A_out          = SEL_A_MEM;
    sel_B_out          = 1'b0;
    alu_op_out         = ALU_ADD;
    acc_wr_out         = 1'b0;
    status_wr_out      = 1'b0;
    data_memory_wr_out = 1'b0;
    pc_load            = 1'b0;
    pc_inc             = 1'b0;

    if (!reset_in) begin
      case (state)
        FETCH: next_state = LATCH;

        LATCH: begin
          if (fetched_op == OP_HLT) begin
            next_state = HALT;
          end else if (needs_mem_read(fetched_op)) begin
            next_state = MEM;
          end else begin
            next_state = EXEC;
          end
        end

        MEM: next_state = EXEC;

        EXEC: begin
`ifdef CONTROL_UNIT_STEP_EN
          next_state = PAUSE;
`else
          next_state = FETCH;
`endif
          case (exec_op)
            OP_STO: data_memory_wr_out = 1'b1;
            OP_LD: begin
              sel_A_out  = SEL_A_MEM;
              acc_wr_out = 1'b1;
            end
            OP_LDI: begin
              sel_A_out  = SEL_A_EXT;
              acc_wr_out = 1'b1;
            end
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
              sel_A_out     = SEL_A_ALU;
              sel_B_out     = (exec_op == OP_ADDI) || (exec_op == OP_SUBI);
              alu_op_out    = ((exec_op == OP_SUB) || (exec_op == OP_SUBI)) ? ALU_SUB : ALU_ADD;
              acc_wr_out    = 1'b1;
              status_wr_out = 1'b1;
            end
            default: ;
          endcase
          pc_load = branch_taken(exec_op, status_Z_in, status_N_in);
          pc_inc  = !pc_load;
        end

        HALT: next_state = HALT;

`ifdef CONTROL_UNIT_STEP_EN
        PAUSE: begin
          if (step_in) begin
            next_state = FETCH;
          end
        end
`endif

        default: next_state = FETCH;
      endcase
    end
  end

  // Address/status outputs, forced to zero while reset is held.
  assign program_address_out = reset_in ? '0 : pc;
  assign operand_out         = reset_in ? '0 : ir[OPERAND_WIDTH-1:0];
  assign halted_out          = !reset_in && (state == HALT);
  assign acc_reset_out       = reset_in;
  assign status_reset_out    = reset_in;

endmodule : control_unit

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit. Each program step pushes per-cycle
// records (inputs to drive plus the expected output vector) into a queue;
// the run loop pops one record per clock, drives it and compares.
// Expected vector: {acc_reset, status_reset, address[10:0], operand[10:0],
//                   halted, dmem_wr, status_wr, acc_wr, alu_op, sel_b, sel_a[1:0]}
module tb_control_unit;

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LD   = 8'b0001_0000;
  localparam logic [7:0] C_LDI  = 8'b0001_0001;
  localparam logic [7:0] C_ADD  = 8'b0011_0010;
  localparam logic [7:0] C_ADDI = 8'b0011_0110;
  localparam logic [7:0] C_SUB  = 8'b0011_1010;
  localparam logic [7:0] C_SUBI = 8'b0011_1110;
  localparam logic [7:0] C_STO  = 8'b0100_0000;
  localparam logic [7:0] C_HALT = 8'b1000_0000;

  logic        clk;
  logic        rst;
  logic        z;
  logic        n;
  logic [15:0] pmem_data;
  logic [10:0] addr;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        alu_op;
  logic        acc_wr;
  logic        status_wr;
  logic        acc_reset;
  logic        status_reset;
  logic        dmem_wr;
  logic        halted;
`ifdef CONTROL_UNIT_STEP_EN
  logic        step;
`endif

  logic [15:0] pmem [0:2047];

  control_unit dut (
    .clock_in            (clk),
    .reset_in            (rst),
`ifdef CONTROL_UNIT_STEP_EN
    .step_in             (step),
`endif
    .instruction_in      (pmem_data),
    .status_Z_in         (z),
    .status_N_in         (n),
    .program_address_out (addr),
    .operand_out         (operand),
    .sel_A_out           (sel_a),
    .sel_B_out           (sel_b),
    .alu_op_out          (alu_op),
    .acc_wr_out          (acc_wr),
    .status_wr_out       (status_wr),
    .acc_reset_out       (acc_reset),
    .status_reset_out    (status_reset),
    .data_memory_wr_out  (dmem_wr),
    .halted_out          (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous program memory: data valid one cycle after the address.
  always @(posedge clk) pmem_data <= pmem[addr];

  wire [31:0] observed = {acc_reset, status_reset, addr, operand,
                          halted, dmem_wr, status_wr, acc_wr, alu_op, sel_b, sel_a};

  typedef struct {
    string       tag;
    logic        rst;
    logic        z;
    logic        n;
    logic        step;
    logic [31:0] exp;
  } cyc_t;

  cyc_t        sb[$];
  int          n_checks;
  int          n_fail;
  logic [10:0] m_pc;
  logic [10:0] m_ir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic r, input logic zz, input logic nn,
                      input logic st, input logic [10:0] a, input logic [10:0] opr,
                      input logic [7:0] ctl);
    cyc_t c;
    c.tag  = tag;
    c.rst  = r;
    c.z    = zz;
    c.n    = nn;
    c.step = st;
    c.exp  = {r, r, a, opr, ctl};
    sb.push_back(c);
  endtask

  task automatic reset_cycles(input int k);
    for (int i = 0; i < k; i++) push("reset", 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, C_NONE);
    m_pc = '0;
    m_ir = '0;
  endtask

  // One instruction at m_pc with hand-derived EXEC controls and branch outcome.
  task automatic prog_instr(input string tag, input logic [4:0] op, input logic [10:0] opr,
                            input bit mem, input logic [7:0] ctl, input bit taken,
                            input logic zz, input logic nn, input int halt_cycles);
    pmem[m_pc] = {op, opr};
    push({tag, ".fetch"}, 1'b0, zz, nn, 1'b0, m_pc, m_ir, C_NONE);
    push({tag, ".latch"}, 1'b0, zz, nn, 1'b0, m_pc, m_ir, C_NONE);
    m_ir = opr;
    if (halt_cycles > 0) begin
      for (int i = 0; i < halt_cycles; i++)
        push({tag, ".halt"}, 1'b0, zz, nn, 1'b0, m_pc, m_ir, C_HALT);
    end else begin
      if (mem) push({tag, ".mem"}, 1'b0, zz, nn, 1'b0, m_pc, m_ir, C_NONE);
      push({tag, ".exec"}, 1'b0, zz, nn, 1'b0, m_pc, m_ir, ctl);
      m_pc = taken ? opr : m_pc + 11'd1;
`ifdef CONTROL_UNIT_STEP_EN
      push({tag, ".pause"}, 1'b0, zz, nn, 1'b0, m_pc, m_ir, C_NONE);
      push({tag, ".step"},  1'b0, zz, nn, 1'b1, m_pc, m_ir, C_NONE);
`endif
    end
  endtask

  task automatic run_queue();
    cyc_t c;
    while (sb.size() > 0) begin
      @(negedge clk);
      c   = sb.pop_front();
      rst = c.rst;
      z   = c.z;
      n   = c.n;
`ifdef CONTROL_UNIT_STEP_EN
      step = c.step;
`endif
      #1;
      check(c.tag, observed, c.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d records left", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    z        = 1'b0;
    n        = 1'b0;
`ifdef CONTROL_UNIT_STEP_EN
    step     = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) pmem[i] = 16'h0000;

    // Reset then LDI 5; ADDI 3; STO 7; HLT.
    reset_cycles(2);
    prog_instr("ldi5",  5'b00011, 11'd5, 0, C_LDI,  0, 1'b0, 1'b0, 0);
    prog_instr("addi3", 5'b00101, 11'd3, 0, C_ADDI, 0, 1'b0, 1'b0, 0);
    prog_instr("sto7",  5'b00001, 11'd7, 0, C_STO,  0, 1'b0, 1'b0, 0);
    prog_instr("hlt",   5'b00000, 11'd0, 0, C_NONE, 0, 1'b0, 1'b0, 3);
    run_queue();

    // Memory-read ALU ops, immediate subtract, load and a NOP.
    reset_cycles(2);
    prog_instr("add4",  5'b00100, 11'd4,     1, C_ADD,  0, 1'b0, 1'b0, 0);
    prog_instr("sub5",  5'b00110, 11'd5,     1, C_SUB,  0, 1'b1, 1'b0, 0);
    prog_instr("subi2", 5'b00111, 11'd2,     0, C_SUBI, 0, 1'b0, 1'b1, 0);
    prog_instr("ld9",   5'b00010, 11'd9,     1, C_LD,   0, 1'b0, 1'b0, 0);
    prog_instr("nop",   5'b01111, 11'h155,   0, C_NONE, 0, 1'b1, 1'b1, 0);
    prog_instr("hlt2",  5'b00000, 11'd0,     0, C_NONE, 0, 1'b0, 1'b0, 2);
    run_queue();

    // Branch resolution from Z/N.
    reset_cycles(1);
    prog_instr("beq_t", 5'b01000, 11'h020, 0, C_NONE, 1, 1'b1, 1'b0, 0);
    prog_instr("beq_n", 5'b01000, 11'h040, 0, C_NONE, 0, 1'b0, 1'b0, 0);
    prog_instr("ble_t", 5'b01101, 11'h030, 0, C_NONE, 1, 1'b0, 1'b1, 0);
    prog_instr("bgt_n", 5'b01010, 11'h050, 0, C_NONE, 0, 1'b1, 1'b0, 0);
    prog_instr("bne_t", 5'b01001, 11'h060, 0, C_NONE, 1, 1'b0, 1'b0, 0);
    prog_instr("bge_n", 5'b01011, 11'h070, 0, C_NONE, 0, 1'b0, 1'b1, 0);
    prog_instr("blt_t", 5'b01100, 11'h070, 0, C_NONE, 1, 1'b0, 1'b1, 0);
    prog_instr("hlt3",  5'b00000, 11'd0,   0, C_NONE, 0, 1'b0, 1'b0, 2);
    run_queue();

    // JMP to the top address, NOP there wraps the PC to zero.
    reset_cycles(1);
    prog_instr("jmp",   5'b01110, 11'h7FF, 0, C_NONE, 1, 1'b0, 1'b0, 0);
    prog_instr("nop7ff",5'b11111, 11'h123, 0, C_NONE, 0, 1'b0, 1'b0, 0);
    prog_instr("jmp2",  5'b01110, 11'h7FF, 0, C_NONE, 1, 1'b1, 1'b1, 0);
    run_queue();

    // Reset during the MEM cycle of ADD at address 1 aborts it.
    reset_cycles(1);
    prog_instr("ldi1", 5'b00011, 11'd1, 0, C_LDI, 0, 1'b0, 1'b0, 0);
    pmem[m_pc] = {5'b00100, 11'd4};
    push("abort.fetch", 1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_ir, C_NONE);
    push("abort.latch", 1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_ir, C_NONE);
    m_ir = 11'd4;
    reset_cycles(1);
    run_queue();
    prog_instr("after", 5'b00011, 11'd9, 0, C_LDI, 0, 1'b0, 1'b0, 0);
    prog_instr("hlt4",  5'b00000, 11'd0, 0, C_NONE, 0, 1'b0, 1'b0, 2);
    run_queue();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_control_unit

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle control unit for the 16-bit accumulator processor; sits directly upstream of the datapath.
- Fetches instructions from program memory using an internal program counter (PC) and latches them into an instruction register (IR).
- Decodes the 5-bit opcode and drives the datapath's mux selects, write enables, ALU operation and operand, plus the data-memory write strobe.
- Resolves conditional branches from the datapath's Z/N status flags.

Parameters:
- DATA_WIDTH, 16, instruction and data word width.
- OPERAND_WIDTH, 11, operand field width; also the PC and program-memory address width.
- OPCODE_WIDTH, 5, opcode field width. DATA_WIDTH must equal OPCODE_WIDTH + OPERAND_WIDTH.

Ports:
- clock_in  in  1  system clock; all state changes on the rising edge.
- reset_in  in  1  synchronous, active-high reset.
- instruction_in  in  DATA_WIDTH  program-memory read data; synchronous memory, valid one cycle after the address.
- status_Z_in  in  1  datapath zero flag.
- status_N_in  in  1  datapath negative flag.
- program_address_out  out  OPERAND_WIDTH  program-memory address; equals PC.
- operand_out  out  OPERAND_WIDTH  IR[OPERAND_WIDTH-1:0]; also serves as the data-memory address.
- sel_A_out  out  2  accumulator source select: 00 = data memory, 01 = sign-extended operand, 10 = ALU.
- sel_B_out  out  1  ALU B-input select: 0 = data memory, 1 = extended operand.
- alu_op_out  out  1  ALU operation: 0 = add, 1 = subtract.
- acc_wr_out, status_wr_out  out  1 each  accumulator and status register write enables.
- acc_reset_out, status_reset_out  out  1 each  combinational copies of reset_in.
- data_memory_wr_out  out  1  data-memory write strobe; write data is the datapath's data_out.
- halted_out  out  1  high while in the HALT state.

Behaviour:
- Reset (synchronous, active-high): state <= FETCH, PC <= 0, IR <= 0.
  - While reset_in is high, every output except acc_reset_out and status_reset_out is 0.
  - Reset asserted in any state, including mid-instruction, aborts the instruction; no write strobe is asserted in that cycle.
- States:
  - FETCH: drive PC on program_address_out. Next state: LATCH.
  - LATCH: IR <= instruction_in. Next state: MEM for LD/ADD/SUB; HALT for HLT; otherwise EXEC.
  - MEM: operand_out is stable; the data memory reads; no write strobes. Next state: EXEC.
  - EXEC: single-cycle control assertion and PC update. Next state: FETCH.
  - HALT: all strobes 0, PC held. Left only by reset.
- Cycles per instruction: 3 (immediate, store, branch) or 4 (memory-read ALU/load).
- Opcodes:
  - 00000 HLT.
  - 00001 STO: data_memory_wr_out = 1.
  - 00010 LD: sel_A = 00, acc_wr = 1.
  - 00011 LDI: sel_A = 01, acc_wr = 1.
  - 00100 ADD / 00110 SUB: sel_B = 0, sel_A = 10, acc_wr = 1, status_wr = 1, alu_op = 0 / 1.
  - 00101 ADDI / 00111 SUBI: as ADD / SUB but sel_B = 1.
  - 01000 BEQ: taken if Z.
  - 01001 BNE: taken if !Z.
  - 01010 BGT: taken if !Z && !N.
  - 01011 BGE: taken if !N.
  - 01100 BLT: taken if N.
  - 01101 BLE: taken if N || Z.
  - 01110 JMP: always taken.
  - All other opcodes: NOP.
- PC update in EXEC:
  - Taken branch or JMP: PC <= operand.
  - Otherwise: PC <= PC + 1, modulo 2^OPERAND_WIDTH, so 0x7FF wraps to 0x000.
- Branch flags are sampled in the EXEC cycle. Flags written by the preceding instruction are therefore visible.
- Strobes are asserted only in EXEC, for exactly one cycle. Outside EXEC, sel_A_out, sel_B_out and alu_op_out are 0.

Optional Feature:
- Macro: CONTROL_UNIT_STEP_EN.
- When defined:
  - Adds input step_in (1 bit) and state PAUSE.
  - EXEC transitions to PAUSE instead of FETCH.
  - PAUSE moves to FETCH in the cycle after step_in is sampled high; all strobes are 0 in PAUSE.
  - step_in is ignored in all other states.
  - Reset takes priority over step_in.
- When undefined: no step_in port and no PAUSE state; EXEC goes directly to FETCH.

Decomposition:
- Package cpu_pkg holds:
  - opcode_t enum covering the opcodes above.
  - cu_state_t enum: FETCH, LATCH, MEM, EXEC, HALT, PAUSE.
  - SEL_A_MEM, SEL_A_EXT, SEL_A_ALU localparams.
  - ALU_ADD, ALU_SUB localparams.
- Sub-module program_counter: load, increment, synchronous reset, OPERAND_WIDTH-bit wrap.

Test Plan:
- Reset: hold reset_in 2 cycles -> program_address_out = 0, all strobes 0, acc_reset_out = status_reset_out = 1; first FETCH occurs at address 0 on the cycle after release.
- Program LDI 5; ADDI 3; STO 7; HLT -> acc_wr in cycles 3 and 6 with the expected sel_A/sel_B; data_memory_wr_out high in cycle 9 with operand_out = 7; halted_out high thereafter with PC = 3.
- ADD 4 -> the MEM cycle has no strobes; the following EXEC has sel_B = 0, sel_A = 10, alu_op = 0, acc_wr = status_wr = 1; the instruction takes 4 cycles.
- BEQ 0x20 with Z = 1 -> PC = 0x20; with Z = 0 -> PC = PC + 1. BLE with N = 1, Z = 0 -> taken; BGT with Z = 1 -> not taken.
- JMP 0x7FF, then a NOP at 0x7FF -> next fetch address is 0x000.
- Assert reset_in during MEM of an ADD -> no acc_wr/status_wr pulse; PC = 0 and state FETCH on the following cycle. With CONTROL_UNIT_STEP_EN defined: the FSM idles in PAUSE after EXEC until a 1-cycle step_in pulse, then fetches.
